alu_seq: RTL and testbench

Multi-cycle execute stage for the 8-bit datapath. It consumes the two register-file read operands (RD1/RD2) together with an opcode and destination address, and computes single-cycle logic/arithmetic ops or iterative multiply/divide. It presents the result, destination address and a write-enable pulse directly to the register file's write port (ALUResult / A3 / write_enable).

---
 rtl/alu_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 72 +++++++
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit multi-cycle execute stage.
package alu_pkg;

    localparam int DATA_W      = 8;
    localparam int REG_ADDR_W  = 4;
    localparam int ITER_CYCLES = 8;
    localparam int CNT_W       = $clog2(ITER_CYCLES);

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_MUL,
        OP_DIV
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } alu_state_t;

    function automatic logic is_iter_op(op_t o);
        return (o == OP_MUL) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per step.
// Outputs show the value the registers take after the pending step.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_zero
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic             div_q;
    logic             dz_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // hi_q holds the product high half or the running remainder;
    // lo_q holds the multiplier being consumed or the dividend/quotient.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        fits    = shifted >= {1'b0, b_q};
        diff    = shifted[WIDTH-1:0] - b_q;
        if (div_q) begin
            hi_n = fits ? diff : shifted[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], fits};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign lo       = lo_n;
    assign hi       = hi_n;
    assign div_zero = dz_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            dz_q  <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
            div_q <= is_div;
            dz_q  <= is_div && (b == '0);
        end else if (step) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute stage: single-cycle ALU ops plus 8-step MUL/DIV,
// driving the register-file write port directly.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  rd1,
    input  logic [WIDTH-1:0]  rd2,
    input  logic [ADDR_W-1:0] dest,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  alu_result,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              write_enable,
    output logic              zero,
    output logic              carry
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_t        state;
    alu_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    op_t               op_in;
    op_t               op_q;
    logic [ADDR_W-1:0] dest_q;
    logic              accept;
    logic              capture;

    logic [WIDTH:0]    add_full;
    logic [WIDTH:0]    sub_full;
    logic [WIDTH:0]    shl_full;
    logic [WIDTH-1:0]  res_nxt;
    logic              carry_nxt;

    logic [WIDTH-1:0]  md_lo;
    logic [WIDTH-1:0]  md_hi;
    logic              md_dz;

    assign op_in        = op_t'(op);
    assign ready        = (state == S_IDLE) || (state == S_DONE);
    assign busy         = (state == S_ITER);
    assign done         = (state == S_DONE);
    assign write_enable = done && (wb_addr != '0);
    assign accept       = start && ready;

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .load    (accept && is_iter_op(op_in)),
        .step    (busy),
        .is_div  (op_in == OP_DIV),
        .a       (rd1),
        .b       (rd2),
        .lo      (md_lo),
        .hi      (md_hi),
        .div_zero(md_dz)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept)
                    state_nxt = is_iter_op(op_in) ? S_ITER : S_DONE;
                else
                    state_nxt = S_IDLE;
            end
            S_ITER: begin
                if (cnt == CNT_W'(ITER_CYCLES - 1))
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        add_full  = {1'b0, rd1} + {1'b0, rd2};
        sub_full  = {1'b0, rd1} - {1'b0, rd2};
        shl_full  = {1'b0, rd1} << rd2[SH_W-1:0];
        res_nxt   = '0;
        carry_nxt = 1'b0;
        if (state == S_ITER) begin
            res_nxt   = md_lo;
            carry_nxt = (op_q == OP_DIV) ? md_dz : (md_hi != '0);
        end else begin
            unique case (op_in)
                OP_ADD: {carry_nxt, res_nxt} = add_full;
                OP_SUB: {carry_nxt, res_nxt} = sub_full;
                OP_AND: res_nxt = rd1 & rd2;
                OP_OR:  res_nxt = rd1 | rd2;
                OP_XOR: res_nxt = rd1 ^ rd2;
                // bit WIDTH of the widened shift is the last bit pushed out
                OP_SHL: {carry_nxt, res_nxt} = shl_full;
                OP_MUL, OP_DIV: begin
                end
            endcase
        end
        capture = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= OP_ADD;
            dest_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= '0;
                op_q   <= op_in;
                dest_q <= dest;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result <= '0;
            wb_addr    <= '0;
            zero       <= 1'b1;
            carry      <= 1'b0;
        end else if (capture) begin
            alu_result <= res_nxt;
            wb_addr    <= busy ? dest_q : dest;
            zero       <= (res_nxt == '0);
            carry      <= carry_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq: table of ops plus hand-written
// back-to-back, busy-ignore and mid-iteration reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [3:0] dest;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] alu_result;
    logic [3:0] wb_addr;
    logic       write_enable;
    logic       zero;
    logic       carry;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH (8),
        .ADDR_W(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rd1         (rd1),
        .rd2         (rd2),
        .dest        (dest),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .alu_result  (alu_result),
        .wb_addr     (wb_addr),
        .write_enable(write_enable),
        .zero        (zero),
        .carry       (carry)
    );

    typedef struct {
        op_t        vop;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] d;
        logic [7:0] res;
        logic       c;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(op_t o, logic [7:0] a, logic [7:0] b,
                                logic [3:0] d, logic [7:0] r,
                                logic c, logic z);
        vec_t v;
        v.vop = o;
        v.a   = a;
        v.b   = b;
        v.d   = d;
        v.res = r;
        v.c   = c;
        v.z   = z;
        v.lat = is_iter_op(o) ? 9 : 1;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_we"}, 32'(write_enable), 32'd0);
        check({tag, "_result"}, 32'(alu_result), 32'd0);
        check({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd1);
        check({tag, "_carry"}, 32'(carry), 32'd0);
    endtask

    task automatic check_result(string tag, vec_t v);
        check({tag, "_result"}, 32'(alu_result), 32'(v.res));
        check({tag, "_carry"}, 32'(carry), 32'(v.c));
        check({tag, "_zero"}, 32'(zero), 32'(v.z));
        check({tag, "_wb_addr"}, 32'(wb_addr), 32'(v.d));
        check({tag, "_we"}, 32'(write_enable), 32'(v.d != 4'd0));
    endtask

    task automatic drive(vec_t v);
        start = 1'b1;
        op    = v.vop;
        rd1   = v.a;
        rd2   = v.b;
        dest  = v.d;
    endtask

    task automatic scramble();
        start = 1'b0;
        op    = OP_XOR;
        rd1   = 8'h5A;
        rd2   = 8'hC3;
        dest  = 4'hF;
    endtask

    task automatic do_op(string tag, vec_t v);
        int lat;
        int busy_cnt;
        @(negedge clk);
        drive(v);
        @(negedge clk);
        scramble();
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(v.lat - 1));
        check_result(tag, v);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t v;

        vecs.push_back(mk(OP_ADD, 8'h7F, 8'h01, 4'd1, 8'h80, 1'b0, 1'b0));
        vecs.push_back(mk(OP_ADD, 8'hFF, 8'h01, 4'd2, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(OP_SUB, 8'h03, 8'h05, 4'd3, 8'hFE, 1'b1, 1'b0));
        vecs.push_back(mk(OP_AND, 8'hF0, 8'h3C, 4'd4, 8'h30, 1'b0, 1'b0));
        vecs.push_back(mk(OP_OR,  8'hF0, 8'h0C, 4'd5, 8'hFC, 1'b0, 1'b0));
        vecs.push_back(mk(OP_XOR, 8'hAA, 8'hAA, 4'd6, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(OP_SHL, 8'h81, 8'h01, 4'd7, 8'h02, 1'b1, 1'b0));
        vecs.push_back(mk(OP_SHL, 8'h81, 8'h08, 4'd8, 8'h81, 1'b0, 1'b0));
        vecs.push_back(mk(OP_SHL, 8'h03, 8'h07, 4'd9, 8'h80, 1'b1, 1'b0));
        vecs.push_back(mk(OP_MUL, 8'd13, 8'd11, 4'd4, 8'h8F, 1'b0, 1'b0));
        vecs.push_back(mk(OP_MUL, 8'h10, 8'h10, 4'd10, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(OP_MUL, 8'hFF, 8'hFF, 4'd11, 8'h01, 1'b1, 1'b0));
        vecs.push_back(mk(OP_DIV, 8'd200, 8'd7, 4'd12, 8'h1C, 1'b0, 1'b0));
        vecs.push_back(mk(OP_DIV, 8'h55, 8'h00, 4'd13, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(mk(OP_DIV, 8'd7, 8'd200, 4'd14, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(OP_ADD, 8'h01, 8'h02, 4'd0, 8'h03, 1'b0, 1'b0));
        vecs.push_back(mk(OP_MUL, 8'h03, 8'h04, 4'd0, 8'h0C, 1'b0, 1'b0));

        reset = 1'b1;
        scramble();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // ADD then SUB issued back-to-back from the DONE cycle
        @(negedge clk);
        drive(mk(OP_ADD, 8'hF0, 8'h20, 4'd3, 8'h10, 1'b1, 1'b0));
        @(negedge clk);
        check_result("b2b_add", mk(OP_ADD, 8'hF0, 8'h20, 4'd3,
                                   8'h10, 1'b1, 1'b0));
        check("b2b_add_done", 32'(done), 32'd1);
        drive(mk(OP_SUB, 8'h05, 8'h05, 4'd5, 8'h00, 1'b0, 1'b1));
        @(negedge clk);
        scramble();
        check_result("b2b_sub", mk(OP_SUB, 8'h05, 8'h05, 4'd5,
                                   8'h00, 1'b0, 1'b1));
        check("b2b_sub_done", 32'(done), 32'd1);
        @(negedge clk);
        check("b2b_done_drop", 32'(done), 32'd0);

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start while busy must be dropped, not queued
        v = mk(OP_MUL, 8'd13, 8'd11, 4'd4, 8'h8F, 1'b0, 1'b0);
        @(negedge clk);
        drive(v);
        @(negedge clk);
        scramble();
        lat = 1;
        while (!done && lat < 20) begin
            if (lat == 3)
                drive(mk(OP_ADD, 8'h01, 8'h01, 4'd7, 8'h02, 1'b0, 1'b0));
            else
                scramble();
            @(negedge clk);
            lat++;
        end
        scramble();
        check("ign_latency", 32'(lat), 32'd9);
        check_result("ign", v);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || write_enable) seen++;
        end
        check("ign_no_extra_done", 32'(seen), 32'd0);

        // asynchronous reset in the middle of an iteration
        @(negedge clk);
        drive(mk(OP_MUL, 8'h10, 8'h10, 4'd6, 8'h00, 1'b1, 1'b1));
        @(negedge clk);
        scramble();
        repeat (2) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || write_enable) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        do_op("post_abort",
              mk(OP_ADD, 8'h22, 8'h11, 4'd9, 8'h33, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
